// File: rtl/axi_tdd_ng_pkg.sv
// Shared types for the TDD engine.
// Used by the sequencer and the channel array.
package axi_tdd_ng_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ARMED   = 2'b01,
        WAITING = 2'b10,
        RUNNING = 2'b11
    } state_t;

endpackage

// File: rtl/axi_tdd_ng_sequencer.sv
// TDD frame sequencer: state machine, delay/frame
// counter and burst frame counter driving the channel timebase.
module axi_tdd_ng_sequencer
    import axi_tdd_ng_pkg::*;
#(
    parameter int REGISTER_WIDTH    = 32,
    parameter int BURST_COUNT_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         tdd_enable,
    input  logic                         tdd_sync_en,
    input  logic                         tdd_sync_ext,
    input  logic                         tdd_sync_soft,
    input  logic                         tdd_sync_rst,
    input  logic [REGISTER_WIDTH-1:0]    tdd_startup_delay,
    input  logic [REGISTER_WIDTH-1:0]    tdd_frame_length,
    input  logic [BURST_COUNT_WIDTH-1:0] tdd_burst_count,
    output logic [REGISTER_WIDTH-1:0]    tdd_counter,
    output state_t                       tdd_cstate,
    output logic                         tdd_endof_frame,
    output logic                         tdd_endof_burst
);

    localparam logic [REGISTER_WIDTH-1:0]    R_ONE = REGISTER_WIDTH'(1);
    localparam logic [BURST_COUNT_WIDTH-1:0] B_ONE = BURST_COUNT_WIDTH'(1);

    state_t                       state_nxt;
    logic [REGISTER_WIDTH-1:0]    sh_delay;
    logic [REGISTER_WIDTH-1:0]    sh_len;
    logic [BURST_COUNT_WIDTH-1:0] sh_burst;
    logic [BURST_COUNT_WIDTH-1:0] frame_cnt;
    logic [BURST_COUNT_WIDTH-1:0] frame_cnt_nxt;
    logic [REGISTER_WIDTH-1:0]    counter_nxt;
    logic [REGISTER_WIDTH-1:0]    d_sel;
    logic [REGISTER_WIDTH-1:0]    l_cur;
    logic [REGISTER_WIDTH-1:0]    l_sel;
    logic [BURST_COUNT_WIDTH-1:0] b_sel;
    logic                         trig;
    logic                         restart;
    logic                         capture;
    logic                         delay_done;
    logic                         frame_done;
    logic                         burst_done;
    logic                         eof_nxt;
    logic                         eob_nxt;

    // Trigger decode, restart/capture qualification and end-of-period flags
    always_comb begin
        trig    = tdd_sync_soft | (tdd_sync_en & tdd_sync_ext);
        restart = trig & tdd_sync_rst &
                  ((tdd_cstate == WAITING) | (tdd_cstate == RUNNING));
        capture = tdd_enable & ((trig & (tdd_cstate == ARMED)) | restart);
        d_sel   = capture ? tdd_startup_delay : sh_delay;
        l_cur   = (sh_len == '0) ? R_ONE : sh_len;
        l_sel   = capture ? tdd_frame_length : sh_len;
        if (l_sel == '0) l_sel = R_ONE;
        b_sel   = capture ? tdd_burst_count : sh_burst;
        delay_done = (tdd_counter == sh_delay - R_ONE);
        frame_done = (tdd_cstate == RUNNING) &&
                     (tdd_counter == l_cur - R_ONE);
        burst_done = frame_done && (sh_burst != '0) &&
                     (frame_cnt == sh_burst - B_ONE);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) tdd_cstate <= IDLE;
        else         tdd_cstate <= state_nxt;
    end

    // Next-state logic; disable overrides every other event
    always_comb begin
        state_nxt = tdd_cstate;
        if (!tdd_enable) begin
            state_nxt = IDLE;
        end else if (restart) begin
            state_nxt = (d_sel != '0) ? WAITING : RUNNING;
        end else begin
            unique case (tdd_cstate)
                IDLE:    state_nxt = ARMED;
                ARMED:   if (trig)
                             state_nxt = (d_sel != '0) ? WAITING : RUNNING;
                WAITING: if (delay_done) state_nxt = RUNNING;
                RUNNING: if (burst_done) state_nxt = ARMED;
            endcase
        end
    end

    // Counter/frame-count next values and look-ahead end pulses
    always_comb begin
        counter_nxt   = '0;
        frame_cnt_nxt = '0;
        if (tdd_enable && !capture) begin
            unique case (tdd_cstate)
                WAITING: begin
                    counter_nxt   = delay_done ? '0 : tdd_counter + R_ONE;
                    frame_cnt_nxt = frame_cnt;
                end
                RUNNING: begin
                    counter_nxt   = frame_done ? '0 : tdd_counter + R_ONE;
                    frame_cnt_nxt = !frame_done ? frame_cnt :
                                    burst_done  ? '0 : frame_cnt + B_ONE;
                end
                default: ;
            endcase
        end
        eof_nxt = (state_nxt == RUNNING) && (counter_nxt == l_sel - R_ONE);
        eob_nxt = eof_nxt && (b_sel != '0) &&
                  (frame_cnt_nxt == b_sel - B_ONE);
    end

    // Datapath registers: shadows, counters and registered pulses
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sh_delay        <= '0;
            sh_len          <= '0;
            sh_burst        <= '0;
            frame_cnt       <= '0;
            tdd_counter     <= '0;
            tdd_endof_frame <= 1'b0;
            tdd_endof_burst <= 1'b0;
        end else begin
            if (capture) begin
                sh_delay <= tdd_startup_delay;
                sh_len   <= tdd_frame_length;
                sh_burst <= tdd_burst_count;
            end
            frame_cnt       <= frame_cnt_nxt;
            tdd_counter     <= counter_nxt;
            tdd_endof_frame <= eof_nxt;
            tdd_endof_burst <= eob_nxt;
        end
    end

endmodule

// File: tb/tb_axi_tdd_ng_sequencer.sv
// Directed scoreboard bench for axi_tdd_ng_sequencer.
// Driver queues expected outputs; a negedge monitor compares them.
module tb_axi_tdd_ng_sequencer;
    import axi_tdd_ng_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        tdd_enable;
    logic        tdd_sync_en;
    logic        tdd_sync_ext;
    logic        tdd_sync_soft;
    logic        tdd_sync_rst;
    logic [31:0] tdd_startup_delay;
    logic [31:0] tdd_frame_length;
    logic [31:0] tdd_burst_count;
    logic [31:0] tdd_counter;
    state_t      tdd_cstate;
    logic        tdd_endof_frame;
    logic        tdd_endof_burst;

    typedef struct packed {
        int          cyc;
        logic [1:0]  st;
        logic [31:0] cnt;
        logic        eof;
        logic        eob;
    } exp_t;

    exp_t  q[$];
    string nq[$];
    string phase = "init";
    int    cyc = 0;
    int    checks = 0;
    int    failures = 0;

    axi_tdd_ng_sequencer #(
        .REGISTER_WIDTH(32),
        .BURST_COUNT_WIDTH(32)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .tdd_enable(tdd_enable),
        .tdd_sync_en(tdd_sync_en),
        .tdd_sync_ext(tdd_sync_ext),
        .tdd_sync_soft(tdd_sync_soft),
        .tdd_sync_rst(tdd_sync_rst),
        .tdd_startup_delay(tdd_startup_delay),
        .tdd_frame_length(tdd_frame_length),
        .tdd_burst_count(tdd_burst_count),
        .tdd_counter(tdd_counter),
        .tdd_cstate(tdd_cstate),
        .tdd_endof_frame(tdd_endof_frame),
        .tdd_endof_burst(tdd_endof_burst)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Monitor: pop and compare every expectation due this cycle
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t  e;
            string n;
            e = q.pop_front();
            n = nq.pop_front();
            checks++;
            if (e.cyc != cyc) begin
                failures++;
                $display("FAIL %s stale cyc=%0d now=%0d", n, e.cyc, cyc);
            end else if (tdd_cstate !== state_t'(e.st) ||
                         tdd_counter !== e.cnt ||
                         tdd_endof_frame !== e.eof ||
                         tdd_endof_burst !== e.eob) begin
                failures++;
                $display("FAIL %s cyc=%0d got st=%0d cnt=%0d eof=%0b eob=%0b exp st=%0d cnt=%0d eof=%0b eob=%0b",
                         n, cyc, tdd_cstate, tdd_counter, tdd_endof_frame,
                         tdd_endof_burst, e.st, e.cnt, e.eof, e.eob);
            end
        end
    end

    // Issue one cycle of stimulus and queue the response after the edge
    task automatic tick(input state_t s, input int c,
                        input logic f, input logic b);
        exp_t e;
        e.cyc = cyc + 1;
        e.st  = s;
        e.cnt = c;
        e.eof = f;
        e.eob = b;
        q.push_back(e);
        nq.push_back(phase);
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn            = 1'b0;
        tdd_enable        = 1'b0;
        tdd_sync_en       = 1'b0;
        tdd_sync_ext      = 1'b0;
        tdd_sync_soft     = 1'b0;
        tdd_sync_rst      = 1'b0;
        tdd_startup_delay = 32'd3;
        tdd_frame_length  = 32'd5;
        tdd_burst_count   = 32'd2;

        phase = "reset";
        tick(IDLE, 0, 0, 0);
        tick(IDLE, 0, 0, 0);
        resetn = 1'b1;
        tick(IDLE, 0, 0, 0);

        // D=3 L=5 burst=2 soft trigger
        phase = "arm";
        tdd_enable = 1'b1;
        tick(ARMED, 0, 0, 0);
        tick(ARMED, 0, 0, 0);
        phase = "burst2";
        tdd_sync_soft = 1'b1;
        tick(WAITING, 0, 0, 0);
        tdd_sync_soft = 1'b0;
        tick(WAITING, 1, 0, 0);
        tick(WAITING, 2, 0, 0);
        for (int fr = 0; fr < 2; fr++) begin
            for (int i = 0; i < 4; i++) tick(RUNNING, i, 0, 0);
            tick(RUNNING, 4, 1, (fr == 1));
        end
        tick(ARMED, 0, 0, 0);
        tick(ARMED, 0, 0, 0);

        // D=0 L=1 unlimited, ext trigger gated then accepted
        phase = "ext_gated";
        tdd_startup_delay = 32'd0;
        tdd_frame_length  = 32'd1;
        tdd_burst_count   = 32'd0;
        tdd_sync_ext = 1'b1;
        tick(ARMED, 0, 0, 0);
        phase = "l1_run";
        tdd_sync_en = 1'b1;
        tick(RUNNING, 0, 1, 0);
        tdd_sync_ext = 1'b0;
        tdd_sync_en  = 1'b0;
        for (int i = 0; i < 100; i++) tick(RUNNING, 0, 1, 0);
        phase = "disable";
        tdd_enable = 1'b0;
        tick(IDLE, 0, 0, 0);
        tdd_enable = 1'b1;
        tick(ARMED, 0, 0, 0);

        // L=10 burst=1, length changed mid-frame is not picked up
        phase = "shadow";
        tdd_frame_length = 32'd10;
        tdd_burst_count  = 32'd1;
        tdd_sync_soft = 1'b1;
        tick(RUNNING, 0, 0, 0);
        tdd_sync_soft = 1'b0;
        for (int i = 1; i < 4; i++) tick(RUNNING, i, 0, 0);
        tdd_frame_length = 32'd4;
        for (int i = 4; i < 9; i++) tick(RUNNING, i, 0, 0);
        tick(RUNNING, 9, 1, 1);
        tick(ARMED, 0, 0, 0);
        phase = "shadow_new";
        tdd_sync_soft = 1'b1;
        tick(RUNNING, 0, 0, 0);
        tdd_sync_soft = 1'b0;
        tick(RUNNING, 1, 0, 0);
        tick(RUNNING, 2, 0, 0);
        tick(RUNNING, 3, 1, 1);
        tick(ARMED, 0, 0, 0);

        // Restart at counter 6 of L=10, D=2
        phase = "restart";
        tdd_startup_delay = 32'd2;
        tdd_frame_length  = 32'd10;
        tdd_burst_count   = 32'd0;
        tdd_sync_soft = 1'b1;
        tick(WAITING, 0, 0, 0);
        tdd_sync_soft = 1'b0;
        tick(WAITING, 1, 0, 0);
        for (int i = 0; i < 7; i++) tick(RUNNING, i, 0, 0);
        tdd_sync_soft = 1'b1;
        tdd_sync_rst  = 1'b1;
        tick(WAITING, 0, 0, 0);
        tdd_sync_soft = 1'b0;
        tick(WAITING, 1, 0, 0);
        tick(RUNNING, 0, 0, 0);
        tick(RUNNING, 1, 0, 0);
        phase = "no_rst_ignored";
        tdd_sync_rst  = 1'b0;
        tdd_sync_soft = 1'b1;
        tick(RUNNING, 2, 0, 0);
        tdd_sync_soft = 1'b0;
        for (int i = 3; i < 9; i++) tick(RUNNING, i, 0, 0);
        tick(RUNNING, 9, 1, 0);

        // Disable together with a restart trigger at L-1
        phase = "disable_trig";
        tdd_enable    = 1'b0;
        tdd_sync_soft = 1'b1;
        tdd_sync_rst  = 1'b1;
        tick(IDLE, 0, 0, 0);
        tick(IDLE, 0, 0, 0);
        phase = "idle_trig";
        tdd_enable = 1'b1;
        tick(ARMED, 0, 0, 0);
        tdd_sync_soft = 1'b0;
        tdd_sync_rst  = 1'b0;
        tick(ARMED, 0, 0, 0);

        // Reset during WAITING
        phase = "reset_wait";
        tdd_startup_delay = 32'd3;
        tdd_frame_length  = 32'd5;
        tdd_burst_count   = 32'd2;
        tdd_sync_soft = 1'b1;
        tick(WAITING, 0, 0, 0);
        tdd_sync_soft = 1'b0;
        tick(WAITING, 1, 0, 0);
        resetn = 1'b0;
        tick(IDLE, 0, 0, 0);
        resetn = 1'b1;
        tick(ARMED, 0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_tdd_ng_sequencer.md
# axi_tdd_ng_sequencer

Frame sequencer for the TDD engine. It owns the TDD state machine and the frame counter. It produces the shared `tdd_counter`, `tdd_cstate` and `tdd_endof_frame` timebase that every TDD output channel compares against its `t_high`/`t_low` thresholds. It sits between the register map and the channel array, and turns enable, sync triggers, startup delay, frame length and burst count into a cycle-exact frame schedule.

## Interface
- `REGISTER_WIDTH`, 32, width of the counter, delay and frame-length fields.
- `BURST_COUNT_WIDTH`, 32, width of the burst-count field and of the internal frame counter.
- `clk`  in  1  clock.
- `resetn`  in  1  synchronous, active-low reset.
- `tdd_enable`  in  1  engine enable. Level-sensitive.
- `tdd_sync_en`  in  1  gates `tdd_sync_ext`.
- `tdd_sync_ext`  in  1  external sync pulse, already synchronised to `clk`.
- `tdd_sync_soft`  in  1  software sync pulse. Never gated.
- `tdd_sync_rst`  in  1  when high, a trigger while WAITING/RUNNING restarts the schedule.
- `tdd_startup_delay`  in  REGISTER_WIDTH  cycles from trigger to frame start.
- `tdd_frame_length`  in  REGISTER_WIDTH  frame length in cycles.
- `tdd_burst_count`  in  BURST_COUNT_WIDTH  frames per burst; 0 = unlimited.
- `tdd_counter`  out  REGISTER_WIDTH  delay/frame counter.
- `tdd_cstate`  out  `state_t`  current state.
- `tdd_endof_frame`  out  1  one-cycle pulse on the last cycle of a frame.
- `tdd_endof_burst`  out  1  one-cycle pulse on the last cycle of the last frame of a burst.

## Operation
- Trigger: `trig = tdd_sync_soft | (tdd_sync_en & tdd_sync_ext)`.
- Configuration is captured into shadow registers on every accepted trigger. Input changes have no effect until the next accepted trigger.
- Effective frame length: `L = max(tdd_frame_length, 1)`. Delay `D = tdd_startup_delay`.
- State IDLE: counter 0, frame count 0. Goes to ARMED when `tdd_enable`=1.
- State ARMED: counter 0. On `trig`, capture config; go to WAITING if D≠0, else RUNNING.
- State WAITING: counter increments each cycle. When counter == D-1, the counter clears and the state goes to RUNNING.
- State RUNNING: counter increments each cycle. When counter == L-1:
  - `tdd_endof_frame`=1, counter clears, frame count increments.
  - If burst count ≠0 and frame count == burst count-1: `tdd_endof_burst`=1, frame count clears, state goes to ARMED.
  - Otherwise the state stays RUNNING.
- Restart: `trig` & `tdd_sync_rst` in WAITING or RUNNING recaptures config, clears counter and frame count, and moves to WAITING if D≠0, else RUNNING. No end-of-frame or end-of-burst pulse is emitted on restart.
- A trigger in WAITING/RUNNING with `tdd_sync_rst`=0 is ignored.
- Triggers in IDLE are ignored.
- `tdd_enable`=0 in any state: next cycle IDLE, counter 0, frame count 0, pulses 0. This overrides every other event in the same cycle.
- Counter arithmetic is unsigned, modulo 2^REGISTER_WIDTH. It never wraps in practice because it clears at D-1 or L-1.
- Reset values: `tdd_counter`=0, `tdd_cstate`=IDLE, `tdd_endof_frame`=0, `tdd_endof_burst`=0. Shadow registers and frame count also reset to 0.
- Reset mid-frame: IDLE on the next edge. No end pulses are emitted.

## Timing
- All outputs are registered.
- `tdd_endof_frame` and `tdd_endof_burst` are high in the same cycle that `tdd_counter` shows L-1. `tdd_cstate`=RUNNING in that cycle.
- Enable set at edge k: ARMED visible after edge k+1.
- Trigger sampled at edge t in ARMED: cycle t+1 shows WAITING with counter 0.
- First RUNNING cycle with counter 0 is t+1+D. With D=0 it is t+1.
- Frame n starts at t+1+D+n·L.
- Restart trigger at edge t: counter 0 at t+1. Same latency as from ARMED.
- With L=1, `tdd_endof_frame` is high on every RUNNING cycle.

## Structure
- `state_t` lives in `axi_tdd_ng_pkg`: 2-bit enum IDLE=2'b00, ARMED=2'b01, WAITING=2'b10, RUNNING=2'b11.
- The channel block imports the same package. No new package constants are needed.
- Single module, no sub-modules. Trigger decode, shadow registers, state register, counter and frame counter are all local.

## Test plan
- Enable, soft trigger, D=3, L=5, burst=2 → WAITING counter 0,1,2. RUNNING counter 0..4 twice. `tdd_endof_frame` at both counter==4 cycles. `tdd_endof_burst` on the second only. Then ARMED.
- D=0, L=1, burst=0, ext trigger with `tdd_sync_en`=1 → RUNNING next cycle, `tdd_endof_frame` every cycle for 100 cycles. The same ext pulse with `tdd_sync_en`=0 stays in ARMED.
- RUNNING with L=10, change `tdd_frame_length` to 4 mid-frame → frames stay 10 long. Next trigger after burst end uses 4.
- `tdd_sync_rst`=1, soft trigger at counter==6 of L=10, D=2 → WAITING 0,1, then RUNNING 0. No end pulses emitted. With `tdd_sync_rst`=0 the trigger is ignored.
- Drop `tdd_enable` at counter==L-1 in the same cycle as a trigger → IDLE next cycle, counter 0, no pulses.
- Assert `resetn`=0 mid-WAITING → next edge all outputs at reset values, state IDLE.
